cordic_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one iterative CORDIC sine/cosine engine between `NREQ` requesters. It accepts `{theta, cos}` jobs over per-requester valid/ready handshakes and issues them to the engine one at a time. It collects the engine result and returns it to the originating requester, tagged with its index. It sits between the peripheral register front-ends and the CORDIC engine, which it drives through a dedicated port group.

---
 rtl/cordic_pkg.sv | 23 ++
 rtl/rr_pick.sv | 38 +++
 rtl/cordic_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_cordic_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and types for the CORDIC arbiter slice.
//   ANGLE_W        width of every Q2.16 angle/result word
//   PI, PI_2       Q2.16 angle constants
//   CORDIC_K       CORDIC gain compensation constant (Q2.16)
//   ENGINE_LATENCY clk_en cycles from engine start sample to done pulse
//   arb_state_t    arbiter FSM state encoding
package cordic_pkg;

  localparam int ANGLE_W        = 19;
  localparam int ENGINE_LATENCY = 13;

  localparam logic [ANGLE_W-1:0] PI       = 19'h3243F;
  localparam logic [ANGLE_W-1:0] PI_2     = 19'h1921F;
  localparam logic [ANGLE_W-1:0] CORDIC_K = 19'h09B75;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Searches req starting one past ptr and wrapping modulo NREQ; the first
// set bit wins.
//   req      in   NREQ   request vector
//   ptr      in   IDX_W  index of the previous winner
//   grant    out  NREQ   one-hot winner (all zero when no request)
//   gnt_idx  out  IDX_W  index of the winner (0 when no request)
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    // i = NREQ lands back on ptr itself, so the last winner is only picked
    // again when nobody else is asking.
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        gnt_idx     = cand;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one iterative CORDIC sin/cos engine between NREQ
// requesters. Jobs are accepted round-robin, issued to the engine one at a
// time, and the result is returned to the originating requester.
//
// Optional feature: define CORDIC_ARB_WATCHDOG_EN to add an engine watchdog
// that returns rsp_err=1 / rsp_data=0 after TIMEOUT clk_en cycles in WAIT.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   clk_en        global clock enable, state only advances when high
//   req_valid     per-requester job request
//   req_theta     per-requester Q2.16 angle, requester i at [19i+18:19i]
//   req_cos       per-requester function select (1 = cos, 0 = sin)
//   req_ready     one-hot accept pulse
//   rsp_valid     one-hot result pulse
//   rsp_data      shared Q2.16 result
//   rsp_err       watchdog error, qualified by rsp_valid
//   eng_start     engine start
//   eng_theta     angle to engine, held until the next grant
//   eng_cos       function select to engine, held until the next grant
//   eng_result    engine result
//   eng_done      engine completion pulse
//
// state | meaning
// IDLE  | waiting for a request; grants the round-robin winner
// ISSUE | eng_start high for one clk_en cycle with the latched job
// WAIT  | waiting for eng_done (or watchdog expiry)
// RESP  | rsp_valid pulse to the owning requester
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*ANGLE_W-1:0] req_theta,
  input  logic [NREQ-1:0]         req_cos,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [ANGLE_W-1:0]      rsp_data,
  output logic                    rsp_err,
  output logic                    eng_start,
  output logic [ANGLE_W-1:0]      eng_theta,
  output logic                    eng_cos,
  input  logic [ANGLE_W-1:0]      eng_result,
  input  logic                    eng_done
);

  localparam int IDX_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("cordic_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 31) begin : g_bad_timeout
    $error("cordic_arbiter: TIMEOUT must fit the 5-bit watchdog (1..31)");
  end

  arb_state_t         state_q, state_d;
  // ptr_q doubles as the index of the in-flight job: it is only rewritten
  // at the next grant, after the response has gone out.
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [ANGLE_W-1:0] theta_q, theta_d;
  logic               cos_q, cos_d;
  logic [ANGLE_W-1:0] data_q, data_d;

  logic [NREQ-1:0]    grant;
  logic [IDX_W-1:0]   gnt_idx;
  logic [ANGLE_W-1:0] sel_theta;
  logic               sel_cos;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .grant   (grant),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    sel_theta = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_theta = req_theta[i*ANGLE_W +: ANGLE_W];
    end
  end

  assign sel_cos = |(grant & req_cos);

`ifdef CORDIC_ARB_WATCHDOG_EN
  // Down-counter loaded in ISSUE; expiry when WAIT sees it at zero gives
  // exactly TIMEOUT clk_en cycles in WAIT.
  localparam logic [4:0] WDOG_LOAD = 5'(TIMEOUT - 1);

  logic [4:0] wdog_q, wdog_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    theta_d = theta_q;
    cos_d   = cos_q;
    data_d  = data_q;
`ifdef CORDIC_ARB_WATCHDOG_EN
    wdog_d  = wdog_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          state_d = ST_ISSUE;
          ptr_d   = gnt_idx;
          theta_d = sel_theta;
          cos_d   = sel_cos;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef CORDIC_ARB_WATCHDOG_EN
        wdog_d  = WDOG_LOAD;
`endif
      end
      ST_WAIT: begin
        if (eng_done) begin
          state_d = ST_RESP;
          data_d  = eng_result;
`ifdef CORDIC_ARB_WATCHDOG_EN
          err_d   = 1'b0;
        end else if (wdog_q == 5'd0) begin
          state_d = ST_RESP;
          data_d  = '0;
          err_d   = 1'b1;
        end else begin
          wdog_d  = wdog_q - 5'd1;
`endif
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDX_W'(NREQ - 1);
      theta_q <= '0;
      cos_q   <= 1'b0;
      data_q  <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      theta_q <= theta_d;
      cos_q   <= cos_d;
      data_q  <= data_d;
    end
  end

`ifdef CORDIC_ARB_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else if (clk_en) begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Outputs decode from the state register, so they hold (and pulses
  // stretch) while clk_en is low. req_ready is the combinational grant
  // shown only in IDLE; the transfer completes on the next clk_en edge.
  assign req_ready = (state_q == ST_IDLE) ? grant : '0;
  assign eng_start = (state_q == ST_ISSUE);
  assign eng_theta = theta_q;
  assign eng_cos   = cos_q;
  assign rsp_data  = data_q;

  always_comb begin
    rsp_valid = '0;
    if (state_q == ST_RESP) rsp_valid[ptr_q] = 1'b1;
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
module tb_cordic_arbiter;
  import cordic_pkg::*;

  localparam int NREQ = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    clk_en;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*ANGLE_W-1:0] req_theta;
  logic [NREQ-1:0]         req_cos;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0]         rsp_valid;
  logic [ANGLE_W-1:0]      rsp_data;
  logic                    rsp_err;
  logic                    eng_start;
  logic [ANGLE_W-1:0]      eng_theta;
  logic                    eng_cos;
  logic [ANGLE_W-1:0]      eng_result;
  logic                    eng_done;

  int n_assert = 0;
  int n_fail   = 0;
  int ecount   = 0;
  int rsp_time = 0;
  bit toggle   = 1'b0;
  bit stub_mute = 1'b0;

  always #5 clk = ~clk;

  cordic_arbiter #(.NREQ(NREQ), .TIMEOUT(31)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .req_valid  (req_valid),
    .req_theta  (req_theta),
    .req_cos    (req_cos),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .eng_start  (eng_start),
    .eng_theta  (eng_theta),
    .eng_cos    (eng_cos),
    .eng_result (eng_result),
    .eng_done   (eng_done)
  );

  // Engine stand-in: table of known angles, done pulse 13 clk_en cycles
  // after the start is sampled.
  function automatic logic [18:0] stub_eval(input logic [18:0] th, input logic c);
    case (th)
      19'h0C910: stub_eval = 19'h0B505;
      19'h1921F: stub_eval = c ? 19'h00000 : 19'h10000;
      19'h00000: stub_eval = c ? 19'h10000 : 19'h00000;
      default:   stub_eval = th | {18'h0, c};
    endcase
  endfunction

  logic [4:0] stub_cnt;
  always @(posedge clk) begin
    if (rst) begin
      stub_cnt   <= '0;
      eng_result <= '0;
    end else if (clk_en) begin
      if (eng_start && !stub_mute) begin
        stub_cnt   <= 5'd14;
        eng_result <= stub_eval(eng_theta, eng_cos);
      end else if (stub_cnt != 5'd0) begin
        stub_cnt <= stub_cnt - 5'd1;
      end
    end
  end
  assign eng_done = (stub_cnt == 5'd1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next clk_en-high cycle; sample point is just after negedge.
  task automatic ecyc();
    do begin
      @(negedge clk);
      clk_en = toggle ? ~clk_en : 1'b1;
    end while (!clk_en);
    ecount++;
    #1;
  endtask

  task automatic set_req(input int r, input logic [18:0] th, input logic c);
    req_valid[r] = 1'b1;
    req_theta[r*ANGLE_W +: ANGLE_W] = th;
    req_cos[r] = c;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      clk_en = 1'b1;
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_req_ready"}, req_ready, 0);
    chk({pfx, "_rsp_valid"}, rsp_valid, 0);
    chk({pfx, "_eng_start"}, eng_start, 0);
    chk({pfx, "_rsp_err"},   rsp_err,   0);
    chk({pfx, "_rsp_data"},  rsp_data,  0);
    chk({pfx, "_eng_theta"}, eng_theta, 0);
    chk({pfx, "_eng_cos"},   eng_cos,   0);
  endtask

  // Called in the IDLE cycle where requester r must win; ends in the IDLE
  // cycle right after RESP.
  task automatic serve(input int r, input logic [18:0] th, input logic c,
                       input logic [18:0] exp, input bit drop);
    int lat;
    #1;
    chk("grant", req_ready, 32'(1 << r));
    ecyc();
    if (drop) req_valid[r] = 1'b0;
    chk("eng_start", eng_start, 1);
    chk("eng_theta", eng_theta, th);
    chk("eng_cos", eng_cos, c);
    chk("ready_pulse", req_ready, 0);
    ecyc();
    chk("start_pulse", eng_start, 0);
    lat = 2;
    while (rsp_valid == '0 && lat < 40) begin
      ecyc();
      lat++;
    end
    rsp_time = ecount;
    chk("latency", lat, 16);
    chk("rsp_valid", rsp_valid, 32'(1 << r));
    chk("rsp_data", rsp_data, exp);
    chk("rsp_err", rsp_err, 0);
    ecyc();
    chk("rsp_pulse", rsp_valid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int t0, lat, seen;
    rst = 1'b1; clk_en = 1'b1;
    req_valid = '0; req_theta = '0; req_cos = '0;

    // Reset state
    do_reset();
    chk_reset_vals("reset");

    // Single request: requester 1, sin(pi/4)
    set_req(1, 19'h0C910, 1'b0);
    serve(1, 19'h0C910, 1'b0, 19'h0B505, 1'b1);

    // Simultaneous requests 0 and 2 after reset: 0 first, then 2
    do_reset();
    set_req(0, 19'h00000, 1'b1);
    set_req(2, 19'h1921F, 1'b1);
    serve(0, 19'h00000, 1'b1, 19'h10000, 1'b1);
    t0 = rsp_time;
    serve(2, 19'h1921F, 1'b1, 19'h00000, 1'b1);
    chk("rsp_spacing", rsp_time - t0, 17);

    // Fairness: 1 and 3 held continuously for 8 jobs
    do_reset();
    set_req(1, 19'h00100, 1'b1);
    set_req(3, 19'h00300, 1'b0);
    for (int j = 0; j < 8; j++) begin
      if (j % 2 == 0) serve(1, 19'h00100, 1'b1, 19'h00101, 1'b0);
      else            serve(3, 19'h00300, 1'b0, 19'h00300, 1'b0);
    end
    req_valid = '0;

    // Reset 5 cycles into WAIT
    ecyc();
    set_req(2, 19'h1921F, 1'b0);
    #1;
    chk("mid_grant", req_ready, 32'h4);
    ecyc();
    req_valid[2] = 1'b0;
    repeat (5) ecyc();
    do_reset();
    chk_reset_vals("midrst");
    seen = 0;
    repeat (20) begin
      ecyc();
      if (rsp_valid != '0) seen++;
    end
    chk("midrst_no_rsp", seen, 0);
    set_req(2, 19'h00300, 1'b0);
    set_req(0, 19'h0C910, 1'b1);
    serve(0, 19'h0C910, 1'b1, 19'h0B505, 1'b1);
    serve(2, 19'h00300, 1'b0, 19'h00300, 1'b1);

    // Clock enable toggling every cycle: same results, latency in clk_en cycles
    toggle = 1'b1;
    do_reset();
    set_req(1, 19'h0C910, 1'b0);
    serve(1, 19'h0C910, 1'b0, 19'h0B505, 1'b1);
    @(negedge clk);
    clk_en = 1'b1;
    toggle = 1'b0;
    #1;

    // Engine that never completes
    stub_mute = 1'b1;
    set_req(3, 19'h00300, 1'b0);
    #1;
    chk("wd_grant", req_ready, 32'h8);
    ecyc();
    req_valid[3] = 1'b0;
    lat = 1;
    while (rsp_valid == '0 && lat < 60) begin
      ecyc();
      lat++;
    end
`ifdef CORDIC_ARB_WATCHDOG_EN
    chk("wd_latency", lat, 33);
    chk("wd_rsp_valid", rsp_valid, 32'h8);
    chk("wd_rsp_err", rsp_err, 1);
    chk("wd_rsp_data", rsp_data, 0);
    ecyc();
    chk("wd_rsp_pulse", rsp_valid, 0);
`else
    chk("nowd_wait", lat, 60);
    chk("nowd_rsp_valid", rsp_valid, 0);
    chk("nowd_rsp_err", rsp_err, 0);
    chk("nowd_rsp_data_held", rsp_data, 32'h0B505);
`endif
    stub_mute = 1'b0;
    do_reset();
    chk_reset_vals("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
